// File: rtl/byte_striping_n_if.sv
// Bus bundle for byte_striping_n: word stream in, striped lane groups out.
// master = upstream framing/mux side (drives the word stream),
// slave  = the striper itself.
interface byte_striping_n_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
);
  localparam int AW = $clog2(LANES) + 1;

  logic                      valid_in;
  logic [DATA_W-1:0]         data_in;
  logic [AW-1:0]             active_lanes;
  logic [LANES*DATA_W-1:0]   lane_data;
  logic [LANES-1:0]          lane_valid;
  logic                      group_valid;
  logic                      partial;
  logic [CNT_W-1:0]          group_count;

  modport master (
    output valid_in, data_in, active_lanes,
    input  lane_data, lane_valid, group_valid, partial, group_count
  );

  modport slave (
    input  valid_in, data_in, active_lanes,
    output lane_data, lane_valid, group_valid, partial, group_count
  );
endinterface

// File: rtl/byte_striping_n.sv
// byte_striping_n: round-robin striper of an input word stream across up to
// LANES output lanes. The lane count is latched at the first word of each
// group; a group cut short by valid_in dropping is flushed with per-lane
// valid flags. All outputs are registered; one cycle from last word to
// group_valid.
//
// Optional build macro STRIPE_IDLE_FILL_EN: adds parameter IDLE_WORD, which
// is placed on every lane whose lane_valid is 0 in an emitted group (instead
// of 0). The reset value of lane_data stays 0 in either build.
module byte_striping_n #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int CNT_W  = 16
`ifdef STRIPE_IDLE_FILL_EN
  ,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(8'hBC)
`endif
) (
  input logic              clk_f,
  input logic              reset,
  byte_striping_n_if.slave bus
);

  localparam int PW = $clog2(LANES);
  localparam int AW = PW + 1;
  localparam logic [AW-1:0] LANES_W = AW'(LANES);

`ifdef STRIPE_IDLE_FILL_EN
  localparam logic [DATA_W-1:0] FILL = IDLE_WORD;
`else
  localparam logic [DATA_W-1:0] FILL = '0;
`endif

  logic [PW-1:0]             ptr_q, ptr_d;
  logic [AW-1:0]             n_eff_q, n_eff_d;
  logic [DATA_W-1:0]         stage_q [LANES];
  logic [DATA_W-1:0]         stage_d [LANES];
  logic [LANES*DATA_W-1:0]   lane_data_q, lane_data_d;
  logic [LANES-1:0]          lane_valid_q, lane_valid_d;
  logic                      group_valid_q, group_valid_d;
  logic                      partial_q, partial_d;
  logic [CNT_W-1:0]          group_count_q, group_count_d;

  logic [AW-1:0]             n_req;
  logic [AW-1:0]             n_cur;
  logic                      last_word;
  logic                      flush;

  // Sanitise the requested lane count: 0 or anything above LANES means all lanes.
  always_comb begin
    n_req = bus.active_lanes;
    if (bus.active_lanes == '0 || bus.active_lanes > LANES_W) begin
      n_req = LANES_W;
    end
  end

  // Lane count in force this cycle (a new group picks up the fresh request) and
  // the group-ending conditions.
  always_comb begin
    n_cur     = (ptr_q == '0 && bus.valid_in) ? n_req : n_eff_q;
    last_word = bus.valid_in && ({1'b0, ptr_q} == (n_cur - AW'(1)));
    flush     = !bus.valid_in && (ptr_q != '0);
  end

  // Next-state: stage the incoming word, advance the pointer, and build the
  // output group on completion or flush.
  always_comb begin
    ptr_d         = ptr_q;
    n_eff_d       = n_eff_q;
    stage_d       = stage_q;
    lane_data_d   = lane_data_q;
    lane_valid_d  = lane_valid_q;
    group_valid_d = 1'b0;
    partial_d     = 1'b0;
    group_count_d = group_count_q;

    if (bus.valid_in) begin
      stage_d[ptr_q] = bus.data_in;
      n_eff_d        = n_cur;
      ptr_d          = last_word ? '0 : ptr_q + PW'(1);
    end

    if (last_word) begin
      // stage_d already holds this cycle's word at ptr_q.
      for (int i = 0; i < LANES; i++) begin
        if (AW'(i) < n_cur) begin
          lane_data_d[i*DATA_W +: DATA_W] = stage_d[i];
          lane_valid_d[i]                 = 1'b1;
        end else begin
          lane_data_d[i*DATA_W +: DATA_W] = FILL;
          lane_valid_d[i]                 = 1'b0;
        end
      end
      group_valid_d = 1'b1;
      group_count_d = group_count_q + CNT_W'(1);
    end else if (flush) begin
      for (int i = 0; i < LANES; i++) begin
        if (AW'(i) < {1'b0, ptr_q}) begin
          lane_data_d[i*DATA_W +: DATA_W] = stage_q[i];
          lane_valid_d[i]                 = 1'b1;
        end else begin
          lane_data_d[i*DATA_W +: DATA_W] = FILL;
          lane_valid_d[i]                 = 1'b0;
        end
      end
      ptr_d         = '0;
      group_valid_d = 1'b1;
      partial_d     = 1'b1;
      group_count_d = group_count_q + CNT_W'(1);
    end
  end

  // State and output registers; reset discards any partly staged group.
  always_ff @(posedge clk_f) begin
    if (!reset) begin
      ptr_q         <= '0;
      n_eff_q       <= LANES_W;
      for (int i = 0; i < LANES; i++) begin
        stage_q[i] <= '0;
      end
      lane_data_q   <= '0;
      lane_valid_q  <= '0;
      group_valid_q <= 1'b0;
      partial_q     <= 1'b0;
      group_count_q <= '0;
    end else begin
      ptr_q         <= ptr_d;
      n_eff_q       <= n_eff_d;
      stage_q       <= stage_d;
      lane_data_q   <= lane_data_d;
      lane_valid_q  <= lane_valid_d;
      group_valid_q <= group_valid_d;
      partial_q     <= partial_d;
      group_count_q <= group_count_d;
    end
  end

  assign bus.lane_data   = lane_data_q;
  assign bus.lane_valid  = lane_valid_q;
  assign bus.group_valid = group_valid_q;
  assign bus.partial     = partial_q;
  assign bus.group_count = group_count_q;

endmodule

// File: doc/byte_striping_n.md
Name: byte_striping_n

Overview:
Parametrised successor to the 2-lane byte striper. It distributes an input word stream round-robin across LANES output lanes on a single clock. The number of active lanes is selectable at run time. When valid_in drops mid-group, the partial group is flushed with per-lane valid flags. It sits in phy_tx between the framing/mux stage and the per-lane paralleliser/serialiser blocks.

Parameters:
DATA_W, 8, width of each input word and each lane word.
LANES, 4, number of physical lanes; power of 2, 2..16.
CNT_W, 16, width of the emitted-group counter.

Ports:
clk_f  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-low reset; sampled on posedge clk_f.
valid_in  input  1  data_in carries a word this cycle.
data_in  input  DATA_W  input word.
active_lanes  input  $clog2(LANES)+1  lanes used per group; 0 or >LANES means LANES.
lane_data  output  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]; registered.
lane_valid  output  LANES  per-lane valid for the group on lane_data; registered.
group_valid  output  1  one-cycle strobe: lane_data/lane_valid updated this cycle.
partial  output  1  qualifies group_valid: group was flushed short.
group_count  output  CNT_W  number of groups emitted since reset; wraps.

Behaviour:
- Reset (reset==0 at posedge): lane_data=0, lane_valid=0, group_valid=0, partial=0, group_count=0. Write pointer ptr=0; staging buffer cleared; any partial group is discarded with no flush. Reset has priority over all other events.
- Effective lane count n_eff: latched from active_lanes only when ptr==0 and valid_in==1, i.e. at the first word of a group. It is held until the group completes or flushes. Changes to active_lanes mid-group are ignored.
- Accept: each cycle with valid_in==1, data_in is written to staging[ptr]. ptr then increments, or wraps to 0 when ptr==n_eff-1. No backpressure; the block always accepts.
- Group complete (valid_in==1 and ptr==n_eff-1 at cycle t), at t+1:
  - lane_data = staging contents, including this cycle's word;
  - lane_valid[i]=1 for i<n_eff, else 0;
  - group_valid=1, partial=0, group_count+=1.
- Flush (valid_in==0 and ptr!=0 at cycle t), at t+1:
  - lanes 0..ptr-1 carry the staged words; lane_valid[i]=1 for i<ptr, else 0;
  - unused lanes carry 0;
  - group_valid=1, partial=1, group_count+=1; ptr returns to 0.
- Idle (valid_in==0 and ptr==0): group_valid=0, partial=0. lane_data and lane_valid hold their last values.
- group_valid and partial are one-cycle strobes, low in every cycle without a completion or flush.
- Unused lanes in a full group (i>=n_eff) are driven 0 with lane_valid=0.
- Latency: last word of a group → outputs updated in 1 cycle. With continuous valid_in, throughput is one group every n_eff cycles.
- n_eff==1: every accepted word produces a full group on lane 0 the next cycle.
- group_count wraps from 2^CNT_W-1 to 0 with no flag.
- Back-to-back groups: the completing word and the next group's first word are never the same cycle, so there is no conflict. A flush cycle cannot accept a word, because valid_in==0 by definition.

Optional Feature:
Macro: STRIPE_IDLE_FILL_EN.
- Defined: adds parameter IDLE_WORD (default 8'hBC, width DATA_W). Every lane with lane_valid==0 on a group_valid cycle carries IDLE_WORD instead of 0. This covers both flushed and inactive lanes. The reset value of lane_data is still 0.
- Not defined: unused lanes carry 0; the IDLE_WORD parameter does not exist.

Test Plan:
1. LANES=4, active_lanes=4, valid_in high for 8 cycles with data 01..08 → two group_valid strobes 4 cycles apart. lane_data = {04,03,02,01}, then {08,07,06,05}; lane_valid=4'b1111; partial=0; group_count=2.
2. valid_in high for 6 words 11..16, then low → first group full. Flush 1 cycle after valid_in drops: lane_data={00,00,16,15}, lane_valid=4'b0011, partial=1, group_count=2.
3. active_lanes=2, stream A0..A3 → groups {00,00,A1,A0} and {00,00,A3,A2}, lane_valid=4'b0011, partial=0. Changing active_lanes to 4 after A2 does not affect the second group.
4. active_lanes=0 and active_lanes=7 → both behave as 4 lanes (same results as scenario 1).
5. Reset asserted with ptr==2 mid-group → next cycle all outputs 0, no flush strobe. A fresh stream after release starts at lane 0.
6. With STRIPE_IDLE_FILL_EN defined, repeat scenario 2 → flushed group lane_data={BC,BC,16,15}.
